hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 36 +++
 rtl/hazard_ctrl_md_timer.sv | 80 ++++++++
 rtl/hazard_ctrl.sv | 92 +++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - md_state_t   : multiply/divide sequencer state encoding
//   - MUL_LAT      : busy cycles of a multiply
//   - DIV_LAT      : busy cycles of a divide
//   - md_load_value: initial value of the down-counter for an operation
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

   // Sequencer state: idle, or an operation occupying the HI/LO unit.
   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_t;

   // Number of cycles MD_Busy stays high for each operation type.
   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 32;

   // Width of the down-counter; holds LAT-1 for the longest operation.
   localparam int MD_CNT_W = 5;

   // The counter is loaded with LAT-1 so that the cycle where it reads 0 is
   // the last busy cycle, giving exactly LAT busy cycles.
   function automatic logic [MD_CNT_W-1:0] md_load_value(input logic is_div);
      logic [MD_CNT_W-1:0] v;
      if (is_div) begin
         v = MD_CNT_W'(DIV_LAT - 1);
      end else begin
         v = MD_CNT_W'(MUL_LAT - 1);
      end
      return v;
   endfunction

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// -----------------------------------------------------------------------------
// md_timer
// Occupancy timer for the HI/LO multiply/divide unit. A start in MD_IDLE
// loads the down-counter with LAT-1 and enters MD_RUN; the counter then
// counts to 0, and the cycle where it reads 0 is the last busy cycle.
//
// Ports:
//   clk       in   pipeline clock
//   rst       in   synchronous active-high reset (returns to MD_IDLE, count 0)
//   i_start   in   accepted start of a multiply/divide (already qualified)
//   i_is_div  in   1 = divide (32 cycles), 0 = multiply (4 cycles)
//   o_busy    out  unit occupied (state is MD_RUN)
//   o_done    out  pulse on the last busy cycle
// -----------------------------------------------------------------------------
module md_timer
   import hazard_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   input  logic i_is_div,
   output logic o_busy,
   output logic o_done
);

   md_state_t             r_state;
   logic [MD_CNT_W-1:0]   r_cnt;
   logic                  r_busy;
   logic                  r_done;

   // Sequencer state, down-counter and registered busy/done flags.
   // r_done is set one cycle ahead, when the counter is about to reach 0, so
   // that it is high exactly in the MD_RUN cycle with count 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            MD_IDLE: begin
               if (i_start) begin
                  r_state <= MD_RUN;
                  r_cnt   <= md_load_value(i_is_div);
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end else begin
                  r_state <= MD_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end
            end
            MD_RUN: begin
               if (r_cnt == '0) begin
                  // Last busy cycle: leave without decrementing, so no wrap.
                  r_state <= MD_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end else begin
                  r_state <= MD_RUN;
                  r_cnt   <= r_cnt - MD_CNT_W'(1);
                  r_busy  <= 1'b1;
                  r_done  <= (r_cnt == MD_CNT_W'(1));
               end
            end
            default: begin
               r_state <= MD_IDLE;
               r_cnt   <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: detects load-use hazards and HI/LO unit
// conflicts, turns them into PC/IF-ID stalls plus an ID/EX bubble, and
// applies branch-mispredict flushes, which take priority over any stall.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ID_Rs, ID_Rt      [4:0]   source registers of the instruction in ID
//   ID_UsesRs/ID_UsesRt       instruction in ID reads Rs / Rt
//   IE_MemRead                instruction in EX is a load
//   IE_WBAddr         [4:0]   destination register of the instruction in EX
//   ID_MulDiv, ID_IsDiv       ID starts a multiply (IsDiv=0) or divide (IsDiv=1)
//   ID_UsesHiLo               ID reads HI/LO (mfhi/mflo)
//   IE_Mispredict             branch in EX was mispredicted
//   PC_Stall, IF_ID_Stall     hold PC and IF/ID (combinational)
//   IF_ID_Flush, ID_EX_Flush  bubble into IF/ID, ID/EX (combinational)
//   MD_Busy, MD_Done          HI/LO unit occupied / last busy cycle
// -----------------------------------------------------------------------------
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] ID_Rs,
   input  logic [4:0] ID_Rt,
   input  logic       ID_UsesRs,
   input  logic       ID_UsesRt,
   input  logic       IE_MemRead,
   input  logic [4:0] IE_WBAddr,
   input  logic       ID_MulDiv,
   input  logic       ID_IsDiv,
   input  logic       ID_UsesHiLo,
   input  logic       IE_Mispredict,
   output logic       PC_Stall,
   output logic       IF_ID_Stall,
   output logic       IF_ID_Flush,
   output logic       ID_EX_Flush,
   output logic       MD_Busy,
   output logic       MD_Done
);

   logic w_load_use;
   logic w_md_hazard;
   logic w_stall;
   logic w_md_start;
   logic w_md_busy;
   logic w_md_done;

   // Hazard detection and stall/flush resolution.
   // Register 0 is hardwired, so a load targeting it never creates a
   // dependency. Stall only depends on MD_Busy, which is registered, so the
   // start qualification below forms no combinational loop.
   always_comb begin
      w_load_use  = 1'b0;
      w_md_hazard = 1'b0;
      w_stall     = 1'b0;
      w_md_start  = 1'b0;
      if (IE_MemRead && (IE_WBAddr != 5'd0)) begin
         w_load_use = (ID_UsesRs && (IE_WBAddr == ID_Rs)) ||
                      (ID_UsesRt && (IE_WBAddr == ID_Rt));
      end else begin
         w_load_use = 1'b0;
      end
      w_md_hazard = w_md_busy && (ID_MulDiv || ID_UsesHiLo);
      if (IE_Mispredict) begin
         // The flush discards the ID instruction, so stalling it is moot.
         w_stall    = 1'b0;
         w_md_start = 1'b0;
      end else begin
         w_stall    = w_load_use || w_md_hazard;
         w_md_start = ID_MulDiv && !w_stall;
      end
   end

   md_timer u_md_timer (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_md_start),
      .i_is_div (ID_IsDiv),
      .o_busy   (w_md_busy),
      .o_done   (w_md_done)
   );

   assign PC_Stall    = w_stall;
   assign IF_ID_Stall = w_stall;
   assign IF_ID_Flush = IE_Mispredict;
   assign ID_EX_Flush = w_stall || IE_Mispredict;
   assign MD_Busy     = w_md_busy;
   assign MD_Done     = w_md_done;

endmodule
